// File: rtl/braille_reader.sv
// Braille cell reader: synchronised, debounced commit/clear buttons push decoded
// 6-dot letter codes (1=a .. 26=z) into a four-entry display buffer.

module braille_debounce #(
    parameter int DEBOUNCE = 250000,
    parameter int CNT_W    = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_s,
    output logic accept_s
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fill_q, fill_d;
    logic               arm_q, arm_d;

    // State, debounce counter and arming registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= 2'd0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            arm_q   <= arm_d;
        end
    end

    // Next-state logic; a press is only seen after a genuine released sample,
    // so a button still held through reset cannot commit until pressed again.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        fill_d   = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        arm_d    = arm_q | ((fill_q == 2'd2) & key_n_s);
        case (state_q)
            IDLE: begin
                if (!key_n_s && arm_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!key_n_s) begin
                    if (cnt_q == LAST) begin
                        state_d  = HELD;
                        cnt_d    = '0;
                        accept_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (key_n_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (key_n_s) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

module braille_reader #(
    parameter int DEBOUNCE = 250000,
    parameter int CNT_W    = 18
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [5:0] SW,
    input  logic [1:0] KEY,
    output logic [4:0] code0,
    output logic [4:0] code1,
    output logic [4:0] code2,
    output logic [4:0] code3,
    output logic [2:0] count,
    output logic       err,
    output logic       char_valid
);
    // Bit k of the pattern is dot k+1; anything not a Grade-1 letter maps to 0.
    function automatic logic [4:0] decode(input logic [5:0] dots);
        logic [4:0] c;
        case (dots)
            6'b000001: c = 5'd1;
            6'b000011: c = 5'd2;
            6'b001001: c = 5'd3;
            6'b011001: c = 5'd4;
            6'b010001: c = 5'd5;
            6'b001011: c = 5'd6;
            6'b011011: c = 5'd7;
            6'b010011: c = 5'd8;
            6'b001010: c = 5'd9;
            6'b011010: c = 5'd10;
            6'b000101: c = 5'd11;
            6'b000111: c = 5'd12;
            6'b001101: c = 5'd13;
            6'b011101: c = 5'd14;
            6'b010101: c = 5'd15;
            6'b001111: c = 5'd16;
            6'b011111: c = 5'd17;
            6'b010111: c = 5'd18;
            6'b001110: c = 5'd19;
            6'b011110: c = 5'd20;
            6'b100101: c = 5'd21;
            6'b100111: c = 5'd22;
            6'b111010: c = 5'd23;
            6'b101101: c = 5'd24;
            6'b111101: c = 5'd25;
            6'b110101: c = 5'd26;
            default:   c = 5'd0;
        endcase
        return c;
    endfunction

    logic [5:0] sw_s1_q, sw_s2_q;
    logic [1:0] key_s1_q, key_s2_q;
    logic       commit_s, clear_s;
    logic [4:0] new_code_s;
    logic [4:0] code0_q, code0_d, code1_q, code1_d, code2_q, code2_d, code3_q, code3_d;
    logic [2:0] count_q, count_d;
    logic       err_q, err_d, char_valid_q, char_valid_d;

    // Two-flop synchronisers; buttons reset to the released level
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_s1_q  <= 6'd0;
            sw_s2_q  <= 6'd0;
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
        end else begin
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
        end
    end

    braille_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_commit (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n_s(key_s2_q[0]), .accept_s(commit_s)
    );

    braille_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_clear (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n_s(key_s2_q[1]), .accept_s(clear_s)
    );

    assign new_code_s = decode(sw_s2_q);

    // Buffer update; clear has priority over a same-cycle commit
    always_comb begin
        code0_d      = code0_q;
        code1_d      = code1_q;
        code2_d      = code2_q;
        code3_d      = code3_q;
        count_d      = count_q;
        err_d        = err_q;
        char_valid_d = 1'b0;
        if (clear_s) begin
            code0_d = 5'd0;
            code1_d = 5'd0;
            code2_d = 5'd0;
            code3_d = 5'd0;
            count_d = 3'd0;
            err_d   = 1'b0;
        end else if (commit_s) begin
            if (new_code_s != 5'd0) begin
                code3_d      = code2_q;
                code2_d      = code1_q;
                code1_d      = code0_q;
                code0_d      = new_code_s;
                count_d      = (count_q == 3'd4) ? count_q : count_q + 3'd1;
                err_d        = 1'b0;
                char_valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            char_valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            code0_q      <= 5'd0;
            code1_q      <= 5'd0;
            code2_q      <= 5'd0;
            code3_q      <= 5'd0;
            count_q      <= 3'd0;
            err_q        <= 1'b0;
            char_valid_q <= 1'b0;
        end else begin
            code0_q      <= code0_d;
            code1_q      <= code1_d;
            code2_q      <= code2_d;
            code3_q      <= code3_d;
            count_q      <= count_d;
            err_q        <= err_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign code0      = code0_q;
    assign code1      = code1_q;
    assign code2      = code2_q;
    assign code3      = code3_q;
    assign count      = count_q;
    assign err        = err_q;
    assign char_valid = char_valid_q;
endmodule

// File: tb/tb_braille_reader.sv
// Directed bench for braille_reader with a short debounce window.

module tb_braille_reader;
    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [5:0] SW;
    logic [1:0] KEY;
    logic [4:0] code0, code1, code2, code3;
    logic [2:0] count;
    logic       err, char_valid;

    int checks   = 0;
    int failures = 0;
    int cv_cnt   = 0;
    int cv_base;

    braille_reader #(.DEBOUNCE(4), .CNT_W(3)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SW(SW), .KEY(KEY),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .count(count), .err(err), .char_valid(char_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Tally char_valid pulses away from the active edge
    always @(negedge CLOCK_50) if (char_valid === 1'b1) cv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input logic [5:0] sw, input int hold);
        SW = sw;
        KEY[0] = 1'b0;
        step(hold);
        KEY[0] = 1'b1;
        step(10);
    endtask

    initial begin
        RESET_N = 1'b0;
        KEY = 2'b11;
        SW = 6'd0;
        step(3);
        check("rst_code0", code0, 0);
        check("rst_code3", code3, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_cv", char_valid, 0);
        RESET_N = 1'b1;
        step(4);

        // Clean press of 'a' with latency check: commit 2 + 4 edges after the fall
        SW = 6'b000001;
        KEY[0] = 1'b0;
        step(5);
        check("lat_early_code0", code0, 0);
        step(1);
        check("lat_code0", code0, 1);
        check("lat_cv_high", char_valid, 1);
        step(1);
        check("lat_cv_low", char_valid, 0);
        step(13);
        KEY[0] = 1'b1;
        step(10);
        check("a_count", count, 1);
        check("a_cv_pulses", cv_cnt, 1);

        // b r a i l: buffer keeps only the last four
        press(6'b000011, 20);
        press(6'b010111, 20);
        press(6'b000001, 20);
        press(6'b001010, 20);
        press(6'b000111, 20);
        check("brail_code0", code0, 12);
        check("brail_code1", code1, 9);
        check("brail_code2", code2, 1);
        check("brail_code3", code3, 18);
        check("brail_count", count, 4);
        check("brail_cv", cv_cnt, 6);

        // Invalid pattern, then 'w'
        press(6'b111111, 20);
        check("inv_err", err, 1);
        check("inv_code0", code0, 12);
        check("inv_code3", code3, 18);
        check("inv_cv", cv_cnt, 6);
        press(6'b111010, 20);
        check("w_code0", code0, 23);
        check("w_code1", code1, 12);
        check("w_code3", code3, 1);
        check("w_err", err, 0);

        // Press bounce, then release bounce
        cv_base = cv_cnt;
        SW = 6'b000011;
        KEY[0] = 1'b0; step(3);
        KEY[0] = 1'b1; step(1);
        KEY[0] = 1'b0; step(3);
        KEY[0] = 1'b1; step(1);
        KEY[0] = 1'b0; step(2);
        check("bounce_no_early", cv_cnt, cv_base);
        check("bounce_code0_hold", code0, 23);
        step(8);
        check("bounce_one_commit", cv_cnt, cv_base + 1);
        check("bounce_code0", code0, 2);
        KEY[0] = 1'b1; step(2);
        KEY[0] = 1'b0; step(2);
        KEY[0] = 1'b1; step(10);
        check("rel_bounce_cv", cv_cnt, cv_base + 1);

        // Clear alone (also drops err), then build count=2, then clear+commit together
        press(6'b000000, 20);
        check("zero_err", err, 1);
        KEY[1] = 1'b0; step(20);
        KEY[1] = 1'b1; step(10);
        check("clr_count", count, 0);
        check("clr_code0", code0, 0);
        check("clr_err", err, 0);
        press(6'b000001, 20);
        press(6'b000011, 20);
        check("pre_both_count", count, 2);
        check("pre_both_code1", code1, 1);
        cv_base = cv_cnt;
        SW = 6'b001001;
        KEY = 2'b00; step(20);
        KEY = 2'b11; step(10);
        check("both_code0", code0, 0);
        check("both_code1", code1, 0);
        check("both_count", count, 0);
        check("both_cv", cv_cnt, cv_base);

        // Reset mid PRESS_WAIT with the button held throughout
        cv_base = cv_cnt;
        SW = 6'b000011;
        KEY[0] = 1'b0;
        step(4);
        RESET_N = 1'b0;
        step(2);
        RESET_N = 1'b1;
        step(20);
        check("rst_held_cv", cv_cnt, cv_base);
        check("rst_held_count", count, 0);
        KEY[0] = 1'b1;
        step(10);
        check("rst_rel_cv", cv_cnt, cv_base);
        press(6'b000011, 20);
        check("rst_repress_code0", code0, 2);
        check("rst_repress_count", count, 1);
        check("rst_repress_cv", cv_cnt, cv_base + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
